// File: rtl/btb_nway.sv
// btb_nway: N-way set-associative BTB with 2-bit direction counters and true-LRU replacement
module btb_nway #(
  parameter int ADDR_W = 32,
  parameter int INDEX_BITS = 9,
  parameter int WAYS = 2,
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2,
  localparam int SETS = 1 << INDEX_BITS,
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic [ADDR_W-1:0] Instr_PC_IN_IF,
  input  logic [ADDR_W-1:0] Instr_PC_IN_ID,
  input  logic              is_Branch_IN_ID,
  input  logic              is_Taken_IN_ID,
  input  logic [ADDR_W-1:0] Alt_PC_IN_ID,
  output logic              hit_BTB,
  output logic [ADDR_W-1:0] take_Alt_PC_OUT_IF
);
  logic              valid  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
  logic [ADDR_W-1:0] target [SETS][WAYS];
  logic [1:0]        ctr    [SETS][WAYS];
  logic [AW-1:0]     age    [SETS][WAYS];
  logic [INDEX_BITS-1:0] idx_if, idx_id;
  logic [TAG_W-1:0] tag_if, tag_id;
  logic hit_if, hit_id, any_inv, train, do_wr;
  logic [AW-1:0] way_if, way_id, vic, tw, age_tw;
  logic [1:0] ctr_nx;
  logic unused;
  assign unused = ^{Instr_PC_IN_IF[1:0], Instr_PC_IN_ID[1:0]};
  assign idx_if = Instr_PC_IN_IF[INDEX_BITS+1:2];
  assign idx_id = Instr_PC_IN_ID[INDEX_BITS+1:2];
  assign tag_if = Instr_PC_IN_IF[ADDR_W-1:INDEX_BITS+2];
  assign tag_id = Instr_PC_IN_ID[ADDR_W-1:INDEX_BITS+2];
  always_comb begin
    hit_if = 1'b0;
    way_if = '0;
    hit_id = 1'b0;
    way_id = '0;
    any_inv = 1'b0;
    vic = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[idx_if][w] && tag_q[idx_if][w] == tag_if) begin
        hit_if = 1'b1;
        way_if = AW'(w);
      end
      if (valid[idx_id][w] && tag_q[idx_id][w] == tag_id) begin
        hit_id = 1'b1;
        way_id = AW'(w);
      end
      if (!any_inv && age[idx_id][w] == AW'(WAYS - 1)) vic = AW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[idx_id][w]) begin
        any_inv = 1'b1;
        vic = AW'(w);
      end
    end
    tw = hit_id ? way_id : vic;
    age_tw = age[idx_id][tw];
    ctr_nx = is_Taken_IN_ID ? (ctr[idx_id][tw] == 2'd3 ? 2'd3 : ctr[idx_id][tw] + 2'd1)
                            : (ctr[idx_id][tw] == 2'd0 ? 2'd0 : ctr[idx_id][tw] - 2'd1);
    train = is_Branch_IN_ID && |Instr_PC_IN_ID;
    do_wr = train && (hit_id || is_Taken_IN_ID);
  end
  assign hit_BTB = hit_if && |Instr_PC_IN_IF && ctr[idx_if][way_if][1];
  assign take_Alt_PC_OUT_IF = hit_BTB ? target[idx_if][way_if] : Instr_PC_IN_IF + ADDR_W'(4);
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid[s][w] <= 1'b0;
          ctr[s][w] <= 2'd0;
          age[s][w] <= AW'(w);
        end
    end else if (!STALL) begin
      if (FLUSH) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
      end else if (do_wr) begin
        for (int w = 0; w < WAYS; w++)
          age[idx_id][w] <= AW'(w) == tw ? '0 : age[idx_id][w] < age_tw ? age[idx_id][w] + AW'(1) : age[idx_id][w];
        if (is_Taken_IN_ID) target[idx_id][tw] <= Alt_PC_IN_ID;
        if (hit_id) ctr[idx_id][tw] <= ctr_nx;
        else begin
          valid[idx_id][tw] <= 1'b1;
          tag_q[idx_id][tw] <= tag_id;
          ctr[idx_id][tw] <= 2'd2;
        end
      end
    end
  end
endmodule

// File: tb/tb_btb_nway.sv
// tb_btb_nway: table-driven self-checking bench for btb_nway with a lookup-expectation scoreboard
module tb_btb_nway;
  logic CLK = 1'b0;
  logic RESET, STALL, FLUSH, br, tk, hit;
  logic [31:0] if_pc, id_pc, alt, npc;
  always #5 CLK = ~CLK;
  btb_nway dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .Instr_PC_IN_IF(if_pc), .Instr_PC_IN_ID(id_pc),
    .is_Branch_IN_ID(br), .is_Taken_IN_ID(tk), .Alt_PC_IN_ID(alt),
    .hit_BTB(hit), .take_Alt_PC_OUT_IF(npc)
  );
  typedef struct {
    logic rst, stall, flush, br, tk;
    logic [31:0] id, alt, ifpc;
    logic chk, eh;
    logic [31:0] epc;
  } vec_t;
  typedef struct {
    logic eh;
    logic [31:0] epc;
    int n;
  } exp_t;
  localparam logic [31:0] Q  = 32'h0000_0100;
  localparam logic [31:0] P1 = 32'h0040_0010, P2 = 32'h0040_0810, P3 = 32'h0040_1010;
  localparam logic [31:0] P4 = 32'h0040_0020, P5 = 32'h0040_0040, P6 = 32'h0040_0030;
  localparam logic [31:0] P7 = 32'h0040_0050, P8 = 32'h0040_0060, P9 = 32'h0040_0070;
  localparam logic [31:0] A1 = 32'h0040_0100, A1B = 32'h0040_0200, A2 = 32'h0040_0900;
  localparam logic [31:0] A3 = 32'h0040_1100, A4 = 32'h0040_0500, A5 = 32'h0040_0600;
  localparam logic [31:0] A6 = 32'h0040_0700, A8 = 32'h0040_0A00;
  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0, errors = 0;
  function automatic vec_t mk(input logic rst, stall, flush, b, t, input logic [31:0] id, a, ifpc,
                              input logic chk, eh, input logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.stall = stall; v.flush = flush; v.br = b; v.tk = t;
    v.id = id; v.alt = a; v.ifpc = ifpc; v.chk = chk; v.eh = eh; v.epc = epc;
    return v;
  endfunction
  function automatic vec_t lk(input logic [31:0] ifpc, input logic eh, input logic [31:0] epc);
    return mk(0, 0, 0, 0, 0, 0, 0, ifpc, 1, eh, epc);
  endfunction
  function automatic vec_t tr(input logic [31:0] id, input logic t, input logic [31:0] a, ifpc,
                              input logic eh, input logic [31:0] epc);
    return mk(0, 0, 0, 1, t, id, a, ifpc, 1, eh, epc);
  endfunction
  function automatic vec_t rs();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  task automatic step(input vec_t v, input int n);
    exp_t e;
    @(negedge CLK);
    RESET = v.rst; STALL = v.stall; FLUSH = v.flush; br = v.br; tk = v.tk;
    id_pc = v.id; alt = v.alt; if_pc = v.ifpc;
    if (v.chk) sb.push_back('{eh: v.eh, epc: v.epc, n: n});
    #2;
    if (v.chk) begin
      e = sb.pop_front();
      checks++;
      if (hit !== e.eh || npc !== e.epc) begin
        errors++;
        $display("FAIL vec%0d: hit=%0b pc=%h, expected hit=%0b pc=%h", e.n, hit, npc, e.eh, e.epc);
      end
    end
  endtask
  initial begin
    RESET = 1; STALL = 0; FLUSH = 0; br = 0; tk = 0; id_pc = 0; alt = 0; if_pc = 0;
    tbl.push_back(rs());
    tbl.push_back(lk(P1, 0, P1 + 4));
    tbl.push_back(tr(P1, 1, A1, P1, 0, P1 + 4));
    tbl.push_back(tr(P1, 0, 0, P1, 1, A1));
    tbl.push_back(tr(P1, 0, 0, P1, 0, P1 + 4));
    tbl.push_back(tr(P1, 0, 0, P1, 0, P1 + 4));
    tbl.push_back(tr(P1, 1, A1B, P1, 0, P1 + 4));
    tbl.push_back(tr(P1, 1, A1B, P1, 0, P1 + 4));
    tbl.push_back(tr(P1, 1, A1B, P1, 1, A1B));
    tbl.push_back(tr(P1, 1, A1B, P1, 1, A1B));
    tbl.push_back(tr(P1, 0, 0, P1, 1, A1B));
    tbl.push_back(tr(P1, 0, 0, P1, 1, A1B));
    tbl.push_back(lk(P1, 0, P1 + 4));
    tbl.push_back(rs());
    tbl.push_back(tr(P1, 1, A1, Q, 0, Q + 4));
    tbl.push_back(tr(P2, 1, A2, Q, 0, Q + 4));
    tbl.push_back(tr(P3, 1, A3, Q, 0, Q + 4));
    tbl.push_back(lk(P1, 0, P1 + 4));
    tbl.push_back(lk(P2, 1, A2));
    tbl.push_back(lk(P3, 1, A3));
    tbl.push_back(rs());
    tbl.push_back(tr(P1, 1, A1, Q, 0, Q + 4));
    tbl.push_back(tr(P2, 1, A2, Q, 0, Q + 4));
    tbl.push_back(tr(P1, 1, A1, Q, 0, Q + 4));
    tbl.push_back(tr(P3, 1, A3, Q, 0, Q + 4));
    tbl.push_back(lk(P2, 0, P2 + 4));
    tbl.push_back(lk(P1, 1, A1));
    tbl.push_back(lk(P3, 1, A3));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, P3, 1, 1, A3));
    tbl.push_back(lk(P3, 0, P3 + 4));
    tbl.push_back(lk(P1, 0, P1 + 4));
    tbl.push_back(mk(0, 1, 0, 1, 1, P4, A4, P4, 1, 0, P4 + 4));
    tbl.push_back(lk(P4, 0, P4 + 4));
    tbl.push_back(mk(0, 0, 1, 1, 1, P4, A4, P4, 1, 0, P4 + 4));
    tbl.push_back(lk(P4, 0, P4 + 4));
    tbl.push_back(tr(P5, 1, A5, Q, 0, Q + 4));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, P5, 1, 1, A5));
    tbl.push_back(lk(P5, 1, A5));
    tbl.push_back(mk(0, 1, 0, 1, 0, P5, 0, P5, 1, 1, A5));
    tbl.push_back(lk(P5, 1, A5));
    tbl.push_back(tr(P5, 0, 0, P5, 1, A5));
    tbl.push_back(lk(P5, 0, P5 + 4));
    tbl.push_back(tr(P6, 1, A6, P6, 0, P6 + 4));
    tbl.push_back(lk(P6, 1, A6));
    tbl.push_back(tr(0, 1, 32'h0040_0800, 0, 0, 4));
    tbl.push_back(lk(0, 0, 4));
    tbl.push_back(lk(32'hFFFF_FFFC, 0, 0));
    tbl.push_back(tr(P7, 0, 0, Q, 0, Q + 4));
    tbl.push_back(lk(P7, 0, P7 + 4));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
    step(tr(P8, 1, A8, Q, 0, Q + 4), 100);
    step(mk(1, 0, 1, 1, 1, P9, A8, P8, 1, 1, A8), 101);
    step(lk(P8, 0, P8 + 4), 102);
    step(lk(P9, 0, P9 + 4), 103);
    step(tr(P8, 1, A8, Q, 0, Q + 4), 104);
    step(mk(0, 1, 0, 0, 0, 0, 0, P8, 1, 1, A8), 105);
    step(mk(0, 1, 0, 0, 0, 0, 0, P9, 1, 0, P9 + 4), 106);
    step(mk(0, 1, 0, 0, 0, 0, 0, P8, 1, 1, A8), 107);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
